// File: rtl/cic_integrator_chain_if.sv
// I/Q sample bus for the CIC integrator cascade.
// Carries the sample handshake, clear and scaled results.
interface cic_integrator_chain_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                        i_clear;
  logic signed [IN_WIDTH-1:0]  i_inph_data;
  logic signed [IN_WIDTH-1:0]  i_quad_data;
  logic                        i_valid;
  logic                        o_ready;
  logic signed [OUT_WIDTH-1:0] o_inph_data;
  logic signed [OUT_WIDTH-1:0] o_quad_data;
  logic                        o_valid;
  logic                        i_ready;

  modport master (
    output i_clear,
    output i_inph_data,
    output i_quad_data,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_inph_data,
    input  o_quad_data,
    input  o_valid
  );

  modport slave (
    input  i_clear,
    input  i_inph_data,
    input  i_quad_data,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_inph_data,
    output o_quad_data,
    output o_valid
  );
endinterface

// File: rtl/cic_integrator_chain.sv
// Multi-stage I/Q integrator cascade for the interpolating CIC.
// Wrapping accumulators, shared valid pipeline, stall and scaler.
module cic_integrator_chain #(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_STAGES = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int ROUND_MODE = 0
) (
  input logic                   i_clock,
  input logic                   i_reset,
  cic_integrator_chain_if.slave bus
);
  localparam int D = ACC_WIDTH - OUT_WIDTH;

  typedef logic [ACC_WIDTH-1:0] acc_t;

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("cic_integrator_chain: NUM_STAGES out of 1..8");
  end
  if (ACC_WIDTH < IN_WIDTH) begin : g_bad_acc
    $error("cic_integrator_chain: ACC_WIDTH < IN_WIDTH");
  end
  if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_out
    $error("cic_integrator_chain: OUT_WIDTH > ACC_WIDTH");
  end

  acc_t [NUM_STAGES-1:0] inph_acc_q;
  acc_t [NUM_STAGES-1:0] inph_acc_d;
  acc_t [NUM_STAGES-1:0] quad_acc_q;
  acc_t [NUM_STAGES-1:0] quad_acc_d;
  acc_t [NUM_STAGES-1:0] inph_src;
  acc_t [NUM_STAGES-1:0] quad_src;

  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_d;
  logic [NUM_STAGES-1:0] up_vld;

  logic [OUT_WIDTH-1:0] inph_out_q;
  logic [OUT_WIDTH-1:0] inph_out_d;
  logic [OUT_WIDTH-1:0] quad_out_q;
  logic [OUT_WIDTH-1:0] quad_out_d;
  logic [OUT_WIDTH-1:0] inph_scl;
  logic [OUT_WIDTH-1:0] quad_scl;

  logic out_vld_q;
  logic out_vld_d;

  acc_t inph_ext;
  acc_t quad_ext;

  assign inph_ext = acc_t'($signed(bus.i_inph_data));
  assign quad_ext = acc_t'($signed(bus.i_quad_data));

  // Stage 1 integrates the new sample; later stages the previous accumulator.
  always_comb begin
    inph_src    = '0;
    quad_src    = '0;
    up_vld      = '0;
    inph_src[0] = inph_ext;
    quad_src[0] = quad_ext;
    up_vld[0]   = bus.i_valid;
    for (int s = 1; s < NUM_STAGES; s++) begin
      inph_src[s] = inph_acc_q[s-1];
      quad_src[s] = quad_acc_q[s-1];
      up_vld[s]   = vld_q[s-1];
    end
  end

  if (D == 0) begin : g_pass
    assign inph_scl = inph_acc_q[NUM_STAGES-1];
    assign quad_scl = quad_acc_q[NUM_STAGES-1];
  end else if (ROUND_MODE == 0) begin : g_trunc
    assign inph_scl = inph_acc_q[NUM_STAGES-1][ACC_WIDTH-1:D];
    assign quad_scl = quad_acc_q[NUM_STAGES-1][ACC_WIDTH-1:D];
  end else begin : g_round
    localparam acc_t HALF = acc_t'(1) << (D - 1);
    acc_t inph_rnd;
    acc_t quad_rnd;
    assign inph_rnd = inph_acc_q[NUM_STAGES-1] + HALF;
    assign quad_rnd = quad_acc_q[NUM_STAGES-1] + HALF;
    assign inph_scl = inph_rnd[ACC_WIDTH-1:D];
    assign quad_scl = quad_rnd[ACC_WIDTH-1:D];
  end

  // Advance every token-holding stage unless stalled; clear wins over all.
  always_comb begin
    inph_acc_d = inph_acc_q;
    quad_acc_d = quad_acc_q;
    vld_d      = vld_q;
    inph_out_d = inph_out_q;
    quad_out_d = quad_out_q;
    out_vld_d  = out_vld_q;
    if (bus.i_clear) begin
      inph_acc_d = '0;
      quad_acc_d = '0;
      vld_d      = '0;
      inph_out_d = '0;
      quad_out_d = '0;
      out_vld_d  = 1'b0;
    end else if (bus.i_ready) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (up_vld[s]) begin
          inph_acc_d[s] = inph_acc_q[s] + inph_src[s];
          quad_acc_d[s] = quad_acc_q[s] + quad_src[s];
        end
      end
      vld_d     = up_vld;
      out_vld_d = vld_q[NUM_STAGES-1];
      if (vld_q[NUM_STAGES-1]) begin
        inph_out_d = inph_scl;
        quad_out_d = quad_scl;
      end
    end
  end

  // Accumulator, valid pipeline and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      inph_acc_q <= '0;
      quad_acc_q <= '0;
      vld_q      <= '0;
      inph_out_q <= '0;
      quad_out_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      inph_acc_q <= inph_acc_d;
      quad_acc_q <= quad_acc_d;
      vld_q      <= vld_d;
      inph_out_q <= inph_out_d;
      quad_out_q <= quad_out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.o_ready     = bus.i_ready;
  assign bus.o_inph_data = inph_out_q;
  assign bus.o_quad_data = quad_out_q;
  assign bus.o_valid     = out_vld_q;

endmodule
